// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture, stall/redirect/halt control.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] imem_rd,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        halted,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic [31:0] fetch_cnt
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
   localparam logic [XLEN-1:0] PC_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_DRAIN
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] ipc_q, ipc_d;
   logic [XLEN-1:0] ipc4_q, ipc4_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;
   logic [XLEN-1:0] cnt_q, cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic            misalign_q, misalign_d;
`endif

   // State register and IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_DRAIN;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         ipc_q      <= '0;
         ipc4_q     <= PC_STEP;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ipc_q      <= ipc_d;
         ipc4_q     <= ipc4_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Next-state: redirect beats stall beats normal fetch
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      ipc4_d     = ipc4_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      cnt_d      = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif
      if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
            halted_d   = 1'b1;
            valid_d    = 1'b0;
         end else begin
`endif
            pc_d     = redirect_pc & PC_MASK;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
            state_d  = ST_RUN;
            halted_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         end
`endif
      end else begin
         case (state_q)
            // Memory may have returned garbage/zero during reset; skip one slot
            ST_DRAIN: begin
               valid_d = 1'b0;
               state_d = ST_RUN;
            end
            ST_HALT: begin
               valid_d = 1'b0;
            end
            default: begin
               if (!stall) begin
                  if (imem_rd == '0) begin
                     instr_d  = NOP_INSTR;
                     valid_d  = 1'b0;
                     state_d  = ST_HALT;
                     halted_d = 1'b1;
                  end else begin
                     pc_d    = pc_q + PC_STEP;
                     instr_d = imem_rd;
                     ipc_d   = pc_q;
                     ipc4_d  = pc_q + PC_STEP;
                     valid_d = 1'b1;
                     cnt_d   = cnt_q + XLEN'(1);
                  end
               end
            end
         endcase
      end
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign ifid_instr = instr_q;
   assign ifid_pc    = ipc_q;
   assign ifid_pc4   = ipc4_q;
   assign ifid_valid = valid_q;
   assign halted     = halted_q;
   assign fetch_cnt  = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// stall/redirect/reset traffic against a transaction-level fetch model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst, stall, redirect;
   logic [31:0] redirect_pc, imem_rd, imem_addr, pc;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc4, fetch_cnt;
   logic        ifid_valid, halted;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   logic [31:0] mem [64];
   assign imem_rd = mem[imem_addr[7:2]];

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_rd(imem_rd), .imem_addr(imem_addr),
      .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
      .ifid_valid(ifid_valid), .halted(halted),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalign(misalign),
`endif
      .fetch_cnt(fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: architectural view of the fetch unit
   logic [31:0] m_pc = 32'h0, m_instr, m_ipc, m_ipc4, m_cnt;
   logic        m_valid, m_halted, m_mis;
   bit          m_fresh;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic rd,
                             input logic [31:0] rpc, input logic [31:0] word);
      if (r) begin
         m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 0; m_ipc4 = 4;
         m_valid = 0; m_halted = 0; m_cnt = 0; m_fresh = 1; m_mis = 0;
      end else if (rd) begin
         m_fresh = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (rpc[1:0] != 2'b00) begin
            m_mis = 1; m_halted = 1; m_valid = 0;
         end else begin
            m_pc = rpc; m_instr = NOP_INSTR; m_valid = 0; m_halted = 0;
         end
`else
         m_pc = {rpc[31:2], 2'b00}; m_instr = NOP_INSTR; m_valid = 0; m_halted = 0;
`endif
      end else if (m_fresh) begin
         m_fresh = 0; m_valid = 0;
      end else if (m_halted) begin
         m_valid = 0;
      end else if (!s) begin
         if (word == 32'h0) begin
            m_instr = NOP_INSTR; m_valid = 0; m_halted = 1;
         end else begin
            m_instr = word; m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
         end
      end
   endtask

   task automatic check_all();
      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pc", ifid_pc, m_ipc);
      check("ifid_pc4", ifid_pc4, m_ipc4);
      check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
      check("fetch_cnt", fetch_cnt, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("misalign", 32'(misalign), 32'(m_mis));
`endif
   endtask

   // One clock: drive inputs, advance model, then compare after the edge
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      model_edge(r, s, rd, rpc, mem[m_pc[7:2]]);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run_until_pc(input logic [31:0] target, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (pc == target) break;
         step(0, 0, 0, 32'h0);
      end
      check("reach_pc", pc, target);
   endtask

   logic [31:0] saved_pc;
   logic [31:0] rpc;

   initial begin
      rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0010_0093 + (32'(i) << 20);
      mem[0] = 32'h00A0_0093; mem[1] = 32'h0140_0113; mem[2] = 32'h0020_81B3;
      mem[21] = 32'h0;

      // Reset and drain
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_valid", 32'(ifid_valid), 32'h0);
      check("rst_instr", ifid_instr, NOP_INSTR);
      check("rst_pc4", ifid_pc4, 32'h4);
      step(0, 0, 0, 0);
      check("drain_valid", 32'(ifid_valid), 32'h0);
      check("drain_pc", pc, RESET_PC);

      // First accepts, stall at pc=8, resume
      step(0, 0, 0, 0);
      check("acc0_instr", ifid_instr, 32'h00A0_0093);
      check("acc0_pc", ifid_pc, 32'h0);
      step(0, 0, 0, 0);
      check("acc1_instr", ifid_instr, 32'h0140_0113);
      check("acc1_pc", ifid_pc, 32'h4);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("stall_pc", pc, 32'h8);
         check("stall_instr", ifid_instr, 32'h0140_0113);
         check("stall_cnt", fetch_cnt, 32'h2);
      end
      step(0, 0, 0, 0);
      check("acc2_instr", ifid_instr, 32'h0020_81B3);
      check("acc2_pc", ifid_pc, 32'h8);
      check("acc2_cnt", fetch_cnt, 32'h3);

      // Redirect with simultaneous stall
      run_until_pc(32'h34, 20);
      step(0, 1, 1, 32'h4C);
      check("redir_pc", pc, 32'h4C);
      check("redir_instr", ifid_instr, NOP_INSTR);
      check("redir_valid", 32'(ifid_valid), 32'h0);
      step(0, 0, 0, 0);
      check("redir_ifid_pc", ifid_pc, 32'h4C);

      // Halt on zero word at 0x54, stall ignored
      run_until_pc(32'h54, 10);
      step(0, 0, 0, 0);
      check("halt_flag", 32'(halted), 32'h1);
      for (int i = 0; i < 11; i++) begin
         step(0, 1'($urandom_range(0, 1)), 0, 0);
         check("halt_pc", pc, 32'h54);
         check("halt_valid", 32'(ifid_valid), 32'h0);
      end
      step(0, 0, 1, 32'h0);
      check("unhalt", 32'(halted), 32'h0);
      check("unhalt_pc", pc, 32'h0);
      step(0, 0, 0, 0);
      check("restart_ifid_pc", ifid_pc, 32'h0);

      // Reset while halted
      step(0, 0, 1, 32'h54);
      step(0, 0, 0, 0);
      check("halt2", 32'(halted), 32'h1);
      step(1, 0, 0, 0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_cnt", fetch_cnt, 32'h0);
      check("rst_ifid_pc", ifid_pc, 32'h0);
      step(0, 0, 0, 0);
      check("drain2_valid", 32'(ifid_valid), 32'h0);
      step(0, 0, 0, 0);
      check("refetch_pc", ifid_pc, RESET_PC);
      check("refetch_valid", 32'(ifid_valid), 32'h1);

      // Misaligned redirect
      saved_pc = pc;
      step(0, 0, 1, 32'h4E);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_flag", 32'(misalign), 32'h1);
      check("mis_halted", 32'(halted), 32'h1);
      check("mis_pc", pc, saved_pc);
`else
      check("mask_pc", pc, 32'h4C);
`endif

      // PC wrap at top of address space
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      check("wrap_pc", pc, 32'h0);
      check("wrap_pc4", ifid_pc4, 32'h0);

      // Randomized traffic
      step(1, 0, 0, 0);
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 9))
            0:       rpc = 32'hFFFF_FFFC;
            1, 2:    rpc = $urandom & 32'hFF;
            default: rpc = $urandom & 32'hFC;
         endcase
         step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 9) == 0), rpc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
